// File: rtl/matrix_bank.sv
// matrix_bank: multi-slot matrix element store. It has a user read/write
// port, an ALU read port and an ALU write port. Each slot has its own
// dimension registers, and a background engine can clear a whole slot.
// Elements are packed densely at slot*MAX_DIM^2 + row*MAX_DIM + col.
module matrix_bank #(
    parameter  int DATA_W    = 16,
    parameter  int NUM_SLOTS = 4,
    parameter  int MAX_DIM   = 5,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,

    // user element and dimension port
    input  logic [SLOT_W-1:0] usr_slot,
    input  logic [2:0]        usr_row,
    input  logic [2:0]        usr_col,
    input  logic [DATA_W-1:0] usr_wdata,
    input  logic              usr_we,
    input  logic              usr_re,
    output logic [DATA_W-1:0] usr_rdata,
    output logic              usr_rvalid,
    input  logic [2:0]        usr_dim_m,
    input  logic [2:0]        usr_dim_n,
    input  logic              usr_dim_we,

    // ALU read port
    input  logic [SLOT_W-1:0] alu_rd_slot,
    input  logic [2:0]        alu_rd_row,
    input  logic [2:0]        alu_rd_col,
    input  logic              alu_re,
    output logic [DATA_W-1:0] alu_rdata,
    output logic              alu_rvalid,
    output logic [2:0]        alu_rd_m,
    output logic [2:0]        alu_rd_n,
    output logic              alu_rd_slot_valid,

    // ALU write port
    input  logic [SLOT_W-1:0] alu_wr_slot,
    input  logic [2:0]        alu_wr_row,
    input  logic [2:0]        alu_wr_col,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              alu_we,
    input  logic [2:0]        alu_res_m,
    input  logic [2:0]        alu_res_n,
    input  logic              alu_dim_we,

    // slot-clear engine
    input  logic              clr_req,
    input  logic [SLOT_W-1:0] clr_slot,
    output logic              clr_busy,
    output logic              clr_done,

    // single-cycle status pulses
    output logic              err_range,
    output logic              err_busy,
    output logic              wr_collide
);

    localparam int ELEMS  = MAX_DIM * MAX_DIM;
    localparam int DEPTH  = NUM_SLOTS * ELEMS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(ELEMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ELEMS - 1);

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    // Slot index is legal (matters when NUM_SLOTS is not a power of two).
    function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
        return int'(s) < NUM_SLOTS;
    endfunction

    // Full element coordinate is inside the bank.
    function automatic logic addr_ok(input logic [SLOT_W-1:0] s,
                                     input logic [2:0] r,
                                     input logic [2:0] c);
        return slot_ok(s) && (int'(r) < MAX_DIM) && (int'(c) < MAX_DIM);
    endfunction

    // Dense flat address. Only meaningful when addr_ok holds.
    function automatic logic [ADDR_W-1:0] flat_addr(input logic [SLOT_W-1:0] s,
                                                    input logic [2:0] r,
                                                    input logic [2:0] c);
        return ADDR_W'(int'(s) * ELEMS + int'(r) * MAX_DIM + int'(c));
    endfunction

    // A dimension pair a slot may legally hold.
    function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
        return (m != 3'd0) && (n != 3'd0) &&
               (int'(m) <= MAX_DIM) && (int'(n) <= MAX_DIM);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [2:0]        dim_m_q [NUM_SLOTS];
    logic [2:0]        dim_n_q [NUM_SLOTS];
    logic              valid_q [NUM_SLOTS];

    clr_state_t        state_q, state_d;
    logic [CNT_W-1:0]  clr_cnt_q;
    logic [SLOT_W-1:0] clr_slot_q;
    logic              clr_start, clr_last;
    logic [ADDR_W-1:0] clr_addr;

    logic [ADDR_W-1:0] usr_addr, alu_rd_addr, alu_wr_addr;
    logic              usr_ok, alu_rd_ok, alu_wr_ok;
    logic              usr_blk, alu_blk;
    logic              usr_we_eff, alu_we_eff;
    logic              usr_dim_legal, alu_dim_legal;
    logic              usr_dim_eff, alu_dim_eff;
    logic              el_collide, dim_collide;
    logic              range_err, busy_err;

    assign clr_busy = (state_q == CLEAR);
    assign clr_addr = ADDR_W'(int'(clr_slot_q) * ELEMS + int'(clr_cnt_q));

    // Decode all request qualifiers: range, busy-slot blocking and collisions.
    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        usr_ok        = addr_ok(usr_slot, usr_row, usr_col);
        alu_rd_ok     = addr_ok(alu_rd_slot, alu_rd_row, alu_rd_col);
        alu_wr_ok     = addr_ok(alu_wr_slot, alu_wr_row, alu_wr_col);
        usr_addr      = flat_addr(usr_slot, usr_row, usr_col);
        alu_rd_addr   = flat_addr(alu_rd_slot, alu_rd_row, alu_rd_col);
        alu_wr_addr   = flat_addr(alu_wr_slot, alu_wr_row, alu_wr_col);

        // Writes into the slot being cleared are refused until the clear ends.
        usr_blk       = clr_busy && (usr_slot == clr_slot_q);
        alu_blk       = clr_busy && (alu_wr_slot == clr_slot_q);

        usr_we_eff    = usr_we && usr_ok && !usr_blk;
        alu_we_eff    = alu_we && alu_wr_ok && !alu_blk;
        el_collide    = usr_we_eff && alu_we_eff && (usr_addr == alu_wr_addr);

        usr_dim_legal = slot_ok(usr_slot) && dims_ok(usr_dim_m, usr_dim_n);
        alu_dim_legal = slot_ok(alu_wr_slot) && dims_ok(alu_res_m, alu_res_n);
        usr_dim_eff   = usr_dim_we && usr_dim_legal && !usr_blk;
        alu_dim_eff   = alu_dim_we && alu_dim_legal && !alu_blk;
        dim_collide   = usr_dim_eff && alu_dim_eff && (usr_slot == alu_wr_slot);

        range_err     = ((usr_we || usr_re) && !usr_ok)
                      || (alu_re && !alu_rd_ok)
                      || (alu_we && !alu_wr_ok)
                      || (usr_dim_we && !usr_dim_legal)
                      || (alu_dim_we && !alu_dim_legal)
                      || (clr_req && (state_q == IDLE) && !slot_ok(clr_slot));

        busy_err      = (usr_we && usr_ok && usr_blk)
                      || (alu_we && alu_wr_ok && alu_blk)
                      || (usr_dim_we && usr_dim_legal && usr_blk)
                      || (alu_dim_we && alu_dim_legal && alu_blk);
    end

    // Clear engine next-state logic: start on a legal request, stop after the last element.
    always_comb begin
        state_d   = state_q;
        clr_start = 1'b0;
        clr_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req && slot_ok(clr_slot)) begin
                    state_d   = CLEAR;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d  = IDLE;
                    clr_last = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear engine state register, element counter, target slot and done pulse.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // block samples the pre-edge values no matter how blocks are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_slot_q <= '0;
            clr_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_done <= clr_last;
            if (clr_start) begin
                clr_slot_q <= clr_slot;
                clr_cnt_q  <= '0;
            end else if (clr_last) begin
                clr_cnt_q  <= '0;
            end else if (clr_busy) begin
                clr_cnt_q  <= clr_cnt_q + CNT_W'(1);
            end
        end
    end

    // Element storage: user write first, ALU write overrides it, clear zeroes one element.
    // NOTE: the array has no reset, so it can map onto plain RAM. rst only
    // blocks the writes in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (usr_we_eff) mem[usr_addr]    <= usr_wdata;
            if (alu_we_eff) mem[alu_wr_addr] <= alu_wdata;
            if (clr_busy)   mem[clr_addr]    <= '0;
        end
    end

    // Registered read ports. They return pre-write data and give 0 for illegal addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            usr_rdata  <= '0;
            usr_rvalid <= 1'b0;
            alu_rdata  <= '0;
            alu_rvalid <= 1'b0;
        end else begin
            usr_rvalid <= usr_re;
            alu_rvalid <= alu_re;
            if (usr_re) usr_rdata <= usr_ok    ? mem[usr_addr]    : '0;
            if (alu_re) alu_rdata <= alu_rd_ok ? mem[alu_rd_addr] : '0;
        end
    end

    // Per-slot dimensions and valid flags. ALU beats user, and starting a clear beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                dim_m_q[i] <= '0;
                dim_n_q[i] <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (usr_dim_eff) begin
                dim_m_q[usr_slot] <= usr_dim_m;
                dim_n_q[usr_slot] <= usr_dim_n;
                valid_q[usr_slot] <= 1'b1;
            end
            if (alu_dim_eff) begin
                dim_m_q[alu_wr_slot] <= alu_res_m;
                dim_n_q[alu_wr_slot] <= alu_res_n;
                valid_q[alu_wr_slot] <= 1'b1;
            end
            if (clr_start) begin
                dim_m_q[clr_slot] <= '0;
                dim_n_q[clr_slot] <= '0;
                valid_q[clr_slot] <= 1'b0;
            end
        end
    end

    // Status pulses, registered one cycle after the event that causes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_range  <= 1'b0;
            err_busy   <= 1'b0;
            wr_collide <= 1'b0;
        end else begin
            err_range  <= range_err;
            err_busy   <= busy_err;
            wr_collide <= el_collide || dim_collide;
        end
    end

    // Combinational dimension lookup for the ALU read slot.
    always_comb begin
        alu_rd_m          = '0;
        alu_rd_n          = '0;
        alu_rd_slot_valid = 1'b0;
        if (slot_ok(alu_rd_slot)) begin
            alu_rd_m          = dim_m_q[alu_rd_slot];
            alu_rd_n          = dim_n_q[alu_rd_slot];
            alu_rd_slot_valid = valid_q[alu_rd_slot];
        end
    end

endmodule

// File: tb/tb_matrix_bank.sv
// tb_matrix_bank: directed and randomized checks of matrix_bank against a
// coordinate-indexed reference model of the elements and dimensions.
module tb_matrix_bank;

    localparam int DATA_W    = 16;
    localparam int NUM_SLOTS = 4;
    localparam int MAX_DIM   = 5;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    logic              clk = 1'b0;
    logic              rst;
    logic [SLOT_W-1:0] usr_slot, alu_rd_slot, alu_wr_slot, clr_slot;
    logic [2:0]        usr_row, usr_col, alu_rd_row, alu_rd_col, alu_wr_row, alu_wr_col;
    logic [DATA_W-1:0] usr_wdata, alu_wdata, usr_rdata, alu_rdata;
    logic              usr_we, usr_re, usr_rvalid, usr_dim_we;
    logic [2:0]        usr_dim_m, usr_dim_n, alu_res_m, alu_res_n, alu_rd_m, alu_rd_n;
    logic              alu_re, alu_rvalid, alu_rd_slot_valid, alu_we, alu_dim_we;
    logic              clr_req, clr_busy, clr_done, err_range, err_busy, wr_collide;

    matrix_bank #(.DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .MAX_DIM(MAX_DIM)) dut (
        .clk(clk), .rst(rst),
        .usr_slot(usr_slot), .usr_row(usr_row), .usr_col(usr_col),
        .usr_wdata(usr_wdata), .usr_we(usr_we), .usr_re(usr_re),
        .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
        .usr_dim_m(usr_dim_m), .usr_dim_n(usr_dim_n), .usr_dim_we(usr_dim_we),
        .alu_rd_slot(alu_rd_slot), .alu_rd_row(alu_rd_row), .alu_rd_col(alu_rd_col),
        .alu_re(alu_re), .alu_rdata(alu_rdata), .alu_rvalid(alu_rvalid),
        .alu_rd_m(alu_rd_m), .alu_rd_n(alu_rd_n), .alu_rd_slot_valid(alu_rd_slot_valid),
        .alu_wr_slot(alu_wr_slot), .alu_wr_row(alu_wr_row), .alu_wr_col(alu_wr_col),
        .alu_wdata(alu_wdata), .alu_we(alu_we),
        .alu_res_m(alu_res_m), .alu_res_n(alu_res_n), .alu_dim_we(alu_dim_we),
        .clr_req(clr_req), .clr_slot(clr_slot), .clr_busy(clr_busy), .clr_done(clr_done),
        .err_range(err_range), .err_busy(err_busy), .wr_collide(wr_collide)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model indexed by matrix coordinates.
    logic [DATA_W-1:0] ref_mem [NUM_SLOTS][MAX_DIM][MAX_DIM];
    int                ref_m [NUM_SLOTS];
    int                ref_n [NUM_SLOTS];
    int                ref_v [NUM_SLOTS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        usr_we = 1'b0; usr_re = 1'b0; usr_dim_we = 1'b0;
        alu_re = 1'b0; alu_we = 1'b0; alu_dim_we = 1'b0; clr_req = 1'b0;
    endtask

    task automatic usr_write(input int s, input int r, input int c, input logic [DATA_W-1:0] d);
        usr_slot = SLOT_W'(s); usr_row = 3'(r); usr_col = 3'(c);
        usr_wdata = d; usr_we = 1'b1;
        tick();
        usr_we = 1'b0;
        ref_mem[s][r][c] = d;
    endtask

    task automatic usr_read(input int s, input int r, input int c, input string tag);
        usr_slot = SLOT_W'(s); usr_row = 3'(r); usr_col = 3'(c); usr_re = 1'b1;
        tick();
        usr_re = 1'b0;
        check({tag, "_rvalid"}, usr_rvalid, 1);
        check({tag, "_rdata"}, usr_rdata, ref_mem[s][r][c]);
    endtask

    task automatic alu_read(input int s, input int r, input int c, input string tag);
        alu_rd_slot = SLOT_W'(s); alu_rd_row = 3'(r); alu_rd_col = 3'(c); alu_re = 1'b1;
        tick();
        alu_re = 1'b0;
        check({tag, "_rvalid"}, alu_rvalid, 1);
        check({tag, "_rdata"}, alu_rdata, ref_mem[s][r][c]);
    endtask

    task automatic check_dims(input int s, input string tag);
        alu_rd_slot = SLOT_W'(s);
        #1;
        check({tag, "_m"}, alu_rd_m, ref_m[s]);
        check({tag, "_n"}, alu_rd_n, ref_n[s]);
        check({tag, "_valid"}, alu_rd_slot_valid, ref_v[s]);
    endtask

    task automatic usr_dim(input int s, input int m, input int n, input string tag);
        int ok;
        ok = (m >= 1 && m <= MAX_DIM && n >= 1 && n <= MAX_DIM) ? 1 : 0;
        usr_slot = SLOT_W'(s); usr_dim_m = 3'(m); usr_dim_n = 3'(n); usr_dim_we = 1'b1;
        tick();
        usr_dim_we = 1'b0;
        if (ok == 1) begin
            ref_m[s] = m; ref_n[s] = n; ref_v[s] = 1;
        end
        check({tag, "_err_range"}, err_range, 1 - ok);
        check_dims(s, tag);
    endtask

    // Runaway guard.
    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    // Directed and randomized stimulus sequence.
    initial begin
        int cyc, us, ur, uc, as_, ar, ac, rs, rr, rc, uw, aw, coll, seen_done;
        logic [DATA_W-1:0] du, da, exp_u, exp_a;

        idle();
        usr_slot = '0; usr_row = '0; usr_col = '0; usr_wdata = '0;
        usr_dim_m = '0; usr_dim_n = '0;
        alu_rd_slot = '0; alu_rd_row = '0; alu_rd_col = '0;
        alu_wr_slot = '0; alu_wr_row = '0; alu_wr_col = '0; alu_wdata = '0;
        alu_res_m = '0; alu_res_n = '0; clr_slot = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            ref_m[s] = 0; ref_n[s] = 0; ref_v[s] = 0;
        end

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_usr_rdata", usr_rdata, 0);
        check("rst_usr_rvalid", usr_rvalid, 0);
        check("rst_alu_rdata", alu_rdata, 0);
        check("rst_alu_rvalid", alu_rvalid, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_clr_done", clr_done, 0);
        check("rst_err_range", err_range, 0);
        check("rst_err_busy", err_busy, 0);
        check("rst_wr_collide", wr_collide, 0);
        for (int s = 0; s < NUM_SLOTS; s++) check_dims(s, "rst_dims");

        // Prefill every element with random data
        for (int s = 0; s < NUM_SLOTS; s++)
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    usr_write(s, r, c, DATA_W'($urandom));

        // Basic write/read at slot 1 (2,3), flat address 38
        usr_write(1, 2, 3, 16'h1234);
        usr_read(1, 2, 3, "basic_usr");
        check("basic_value", usr_rdata, 16'h1234);
        tick();
        check("basic_rvalid_drop", usr_rvalid, 0);
        check("basic_rdata_hold", usr_rdata, 16'h1234);
        alu_read(1, 2, 3, "basic_alu");

        // Randomized traffic: both writers, both readers, forced address overlaps
        for (int i = 0; i < 80; i++) begin
            us = $urandom_range(0, NUM_SLOTS - 1); ur = $urandom_range(0, MAX_DIM - 1);
            uc = $urandom_range(0, MAX_DIM - 1);
            if ($urandom_range(0, 2) == 0) begin
                as_ = us; ar = ur; ac = uc;
            end else begin
                as_ = $urandom_range(0, NUM_SLOTS - 1); ar = $urandom_range(0, MAX_DIM - 1);
                ac = $urandom_range(0, MAX_DIM - 1);
            end
            rs = $urandom_range(0, NUM_SLOTS - 1); rr = $urandom_range(0, MAX_DIM - 1);
            rc = $urandom_range(0, MAX_DIM - 1);
            uw = $urandom_range(0, 1); aw = $urandom_range(0, 1);
            du = DATA_W'($urandom); da = DATA_W'($urandom);
            exp_u = ref_mem[us][ur][uc];
            exp_a = ref_mem[rs][rr][rc];
            coll = (uw == 1 && aw == 1 && us == as_ && ur == ar && uc == ac) ? 1 : 0;

            usr_slot = SLOT_W'(us); usr_row = 3'(ur); usr_col = 3'(uc);
            usr_wdata = du; usr_we = uw[0]; usr_re = 1'b1;
            alu_wr_slot = SLOT_W'(as_); alu_wr_row = 3'(ar); alu_wr_col = 3'(ac);
            alu_wdata = da; alu_we = aw[0];
            alu_rd_slot = SLOT_W'(rs); alu_rd_row = 3'(rr); alu_rd_col = 3'(rc); alu_re = 1'b1;
            tick();
            idle();
            if (uw == 1) ref_mem[us][ur][uc] = du;
            if (aw == 1) ref_mem[as_][ar][ac] = da;

            check("rnd_usr_rvalid", usr_rvalid, 1);
            check("rnd_usr_rdata_old", usr_rdata, exp_u);
            check("rnd_alu_rvalid", alu_rvalid, 1);
            check("rnd_alu_rdata", alu_rdata, exp_a);
            check("rnd_wr_collide", wr_collide, coll);
            check("rnd_err_range", err_range, 0);
        end

        // Sweep the whole bank through the ALU read port
        for (int s = 0; s < NUM_SLOTS; s++)
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    alu_read(s, r, c, "sweep");

        // Directed collision at slot 0 (0,0)
        usr_slot = '0; usr_row = '0; usr_col = '0; usr_wdata = 16'hAAAA; usr_we = 1'b1;
        alu_wr_slot = '0; alu_wr_row = '0; alu_wr_col = '0; alu_wdata = 16'h5555; alu_we = 1'b1;
        tick();
        idle();
        ref_mem[0][0][0] = 16'h5555;
        check("coll_pulse", wr_collide, 1);
        tick();
        check("coll_pulse_end", wr_collide, 0);
        usr_read(0, 0, 0, "coll_read");
        check("coll_value", usr_rdata, 16'h5555);

        // Dimension writes
        usr_dim(1, 6, 2, "dim_bad_m6");
        tick();
        check("dim_err_pulse_end", err_range, 0);
        usr_dim(1, 3, 4, "dim_ok_3x4");
        check("dim_m_is_3", alu_rd_m, 3);
        check("dim_n_is_4", alu_rd_n, 4);
        usr_dim(1, 0, 3, "dim_bad_m0");
        usr_dim(1, 5, 5, "dim_max");
        usr_dim(1, 3, 4, "dim_restore");
        // user and ALU write dims of slot 3 in the same cycle
        usr_slot = SLOT_W'(3); usr_dim_m = 3'd2; usr_dim_n = 3'd2; usr_dim_we = 1'b1;
        alu_wr_slot = SLOT_W'(3); alu_res_m = 3'd5; alu_res_n = 3'd1; alu_dim_we = 1'b1;
        tick();
        idle();
        ref_m[3] = 5; ref_n[3] = 1; ref_v[3] = 1;
        check("dimcoll_pulse", wr_collide, 1);
        check_dims(3, "dimcoll");

        // Out-of-range accesses
        alu_rd_slot = '0; alu_rd_row = 3'd5; alu_rd_col = '0; alu_re = 1'b1;
        tick();
        idle();
        check("oor_alu_rvalid", alu_rvalid, 1);
        check("oor_alu_rdata", alu_rdata, 0);
        check("oor_alu_err", err_range, 1);
        tick();
        check("oor_err_end", err_range, 0);
        usr_slot = '0; usr_row = '0; usr_col = 3'd7; usr_wdata = 16'h7777; usr_we = 1'b1;
        tick();
        idle();
        check("oor_usr_wr_err", err_range, 1);
        usr_read(0, 1, 2, "oor_no_alias");

        // Clear slot 2
        usr_dim(2, 5, 5, "pre_clr_dims");
        clr_slot = SLOT_W'(2); clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
                ref_mem[2][r][c] = '0;
        ref_m[2] = 0; ref_n[2] = 0; ref_v[2] = 0;
        check("clr_busy_start", clr_busy, 1);
        check_dims(2, "clr_entry_dims");
        cyc = 0;
        while (clr_busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 5) begin
                usr_slot = SLOT_W'(2); usr_row = 3'd1; usr_col = 3'd1;
                usr_wdata = 16'hBEEF; usr_we = 1'b1;
                alu_wr_slot = '0; alu_wr_row = 3'd4; alu_wr_col = 3'd4;
                alu_wdata = 16'hCAFE; alu_we = 1'b1;
                alu_rd_slot = SLOT_W'(1); alu_rd_row = 3'd3; alu_rd_col = 3'd3; alu_re = 1'b1;
                clr_slot = SLOT_W'(1); clr_req = 1'b1;
            end
            tick();
            if (cyc == 5) begin
                idle();
                ref_mem[0][4][4] = 16'hCAFE;
                check("clr_mid_err_busy", err_busy, 1);
                check("clr_mid_err_range", err_range, 0);
                check("clr_mid_read_other", alu_rdata, ref_mem[1][3][3]);
            end
            if (cyc == 6) check("clr_err_busy_end", err_busy, 0);
        end
        check("clr_busy_cycles", cyc, 25);
        check("clr_done_pulse", clr_done, 1);
        tick();
        check("clr_done_end", clr_done, 0);
        check("clr_busy_end", clr_busy, 0);
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
                usr_read(2, r, c, "clr_zero");
        usr_read(0, 4, 4, "clr_other_slot_write");
        check_dims(2, "clr_after_dims");
        check_dims(1, "clr_req_ignored_dims");

        // Reset in the middle of a clear, with a simultaneous write
        usr_dim(0, 2, 2, "pre_abort_dims");
        clr_slot = SLOT_W'(3); clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_before", clr_busy, 1);
        rst = 1'b1;
        usr_slot = SLOT_W'(1); usr_row = '0; usr_col = '0; usr_wdata = 16'h9999; usr_we = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int s = 0; s < NUM_SLOTS; s++) begin
            ref_m[s] = 0; ref_n[s] = 0; ref_v[s] = 0;
        end
        check("abort_clr_busy", clr_busy, 0);
        check("abort_clr_done", clr_done, 0);
        check("abort_usr_rdata", usr_rdata, 0);
        check("abort_usr_rvalid", usr_rvalid, 0);
        for (int s = 0; s < NUM_SLOTS; s++) check_dims(s, "abort_dims");
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (clr_done === 1'b1) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        usr_read(1, 0, 0, "rst_blocks_write");
        usr_read(0, 4, 4, "mem_kept_over_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
